// File: rtl/sent_pkg.sv
// Shared SENT constants, FSM state encoding and nibble-CRC helpers.
// Used by both the receive decoder and the transmit CRC generator.
package sent_pkg;

   localparam int unsigned LEN_W      = 10;
   localparam int unsigned SYNC_TICKS = 56;
   localparam int unsigned SYNC_TOL   = 1;
   localparam int unsigned NIB_BASE   = 12;
   localparam int unsigned NIB_MAX    = 27;
   localparam int unsigned PAUSE_MAX  = 768;
   localparam logic [3:0]  CRC_SEED   = 4'h5;

   localparam logic [3:0] CRC_TAB [16] = '{
      4'd0,  4'd13, 4'd7,  4'd10, 4'd14, 4'd3,  4'd9,  4'd4,
      4'd1,  4'd12, 4'd6,  4'd11, 4'd15, 4'd2,  4'd8,  4'd5
   };

   // Each state names the pulse that the next falling edge closes.
   typedef enum logic [2:0] {
      ST_HUNT,
      ST_SYNC,
      ST_STATUS,
      ST_DATA,
      ST_CRC,
      ST_PAUSE
   } sent_state_e;

   function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic [3:0] nib);
      return CRC_TAB[crc] ^ nib;
   endfunction

   // Final zero-nibble augmentation step.
   function automatic logic [3:0] crc_final(input logic [3:0] crc);
      return CRC_TAB[crc];
   endfunction

endpackage

// File: rtl/sent_rx_decoder_if.sv
// Decoder control/status bundle: enable and line inputs, last-good-frame
// outputs and the one-cycle event strobes.
interface sent_rx_decoder_if #(
   parameter int NIBBLES = 6
);
   logic                   enable;
   logic                   optional_pause;
   logic                   data_pulse;
   logic [3:0]             status_nibble;
   logic [4*NIBBLES-1:0]   data_fast;
   logic [3:0]             rx_crc;
   logic                   frame_valid;
   logic                   crc_error;
   logic                   pulse_error;
   logic                   busy;

   modport master (
      output enable, optional_pause, data_pulse,
      input  status_nibble, data_fast, rx_crc,
      input  frame_valid, crc_error, pulse_error, busy
   );

   modport slave (
      input  enable, optional_pause, data_pulse,
      output status_nibble, data_fast, rx_crc,
      output frame_valid, crc_error, pulse_error, busy
   );
endinterface

// File: rtl/sent_rx_pulse_meas.sv
// SENT line front end: synchroniser, falling-edge detect and pulse length
// measurement in ticks, rounded to the nearest tick and saturating.
module sent_rx_pulse_meas
   import sent_pkg::*;
#(
   parameter int CLK_PER_TICK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             data_pulse,
   output logic             fe,
   output logic [LEN_W-1:0] len,
   output logic             sat
);

   localparam int CW = $clog2(CLK_PER_TICK);
   localparam logic [LEN_W-1:0] TICK_MAX = '1;

   // [0] metastable stage, [1] synchronised line, [2] previous line value
   logic [2:0]       sync_q;
   logic [CW-1:0]    cc_q;
   logic [LEN_W-1:0] tick_q;
   logic             round_up;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[1:0], data_pulse};
      end
   end

   assign fe = sync_q[2] & ~sync_q[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cc_q   <= '0;
         tick_q <= '0;
      end else if (!enable || fe) begin
         cc_q   <= '0;
         tick_q <= '0;
      end else if (cc_q == CW'(CLK_PER_TICK - 1)) begin
         cc_q <= '0;
         if (tick_q != TICK_MAX) begin
            tick_q <= tick_q + LEN_W'(1);
         end
      end else begin
         cc_q <= cc_q + CW'(1);
      end
   end

   assign round_up = (cc_q >= CW'(CLK_PER_TICK / 2));
   // A saturated count must not wrap when rounded up.
   assign len = (tick_q == TICK_MAX) ? TICK_MAX : tick_q + {{(LEN_W-1){1'b0}}, round_up};
   assign sat = (tick_q == TICK_MAX);

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT fast-channel receive decoder: pulse classification FSM, payload shift
// register and nibble CRC check, with last-good-frame output latches.
module sent_rx_decoder
   import sent_pkg::*;
#(
   parameter int CLK_PER_TICK = 4,
   parameter int NIBBLES      = 6
) (
   input  logic             clk,
   input  logic             reset,
   sent_rx_decoder_if.slave bus
);

   // state      | meaning
   // ST_HUNT    | searching for a 55..57 tick sync pulse
   // ST_SYNC    | next edge closes the sync pulse
   // ST_STATUS  | next edge closes the status nibble
   // ST_DATA    | next edge closes a data nibble
   // ST_CRC     | next edge closes the CRC nibble
   // ST_PAUSE   | next edge closes the optional pause pulse

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES + 1);

   logic             fe;
   logic [LEN_W-1:0] len;
   logic             sat;

   sent_rx_pulse_meas #(
      .CLK_PER_TICK (CLK_PER_TICK)
   ) u_meas (
      .clk        (clk),
      .reset      (reset),
      .enable     (bus.enable),
      .data_pulse (bus.data_pulse),
      .fe         (fe),
      .len        (len),
      .sat        (sat)
   );

   sent_state_e   state_q;
   logic          armed_q;
   logic [IW-1:0] nib_idx_q;
   logic [3:0]    crc_q;
   logic [W-1:0]  shift_q;
   logic [3:0]    stat_q;
   logic [3:0]    status_nibble_q;
   logic [W-1:0]  data_fast_q;
   logic [3:0]    rx_crc_q;
   logic          frame_valid_q;
   logic          crc_error_q;
   logic          pulse_error_q;

   logic       is_sync;
   logic       nib_ok;
   logic       pause_ok;
   logic [3:0] nib;

   assign is_sync  = (len >= LEN_W'(SYNC_TICKS - SYNC_TOL)) && (len <= LEN_W'(SYNC_TICKS + SYNC_TOL));
   assign nib_ok   = (len >= LEN_W'(NIB_BASE)) && (len <= LEN_W'(NIB_MAX));
   assign pause_ok = (len >= LEN_W'(NIB_BASE)) && (len <= LEN_W'(PAUSE_MAX));
   assign nib      = len[3:0] - 4'(NIB_BASE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_HUNT;
         armed_q         <= 1'b0;
         nib_idx_q       <= '0;
         crc_q           <= '0;
         shift_q         <= '0;
         stat_q          <= '0;
         status_nibble_q <= '0;
         data_fast_q     <= '0;
         rx_crc_q        <= '0;
         frame_valid_q   <= 1'b0;
         crc_error_q     <= 1'b0;
         pulse_error_q   <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         crc_error_q   <= 1'b0;
         pulse_error_q <= 1'b0;

         if (!bus.enable) begin
            state_q   <= ST_HUNT;
            armed_q   <= 1'b0;
            nib_idx_q <= '0;
            crc_q     <= '0;
            shift_q   <= '0;
            stat_q    <= '0;
         end else if (fe) begin
            // The very first edge has no valid start point to measure from.
            armed_q <= 1'b1;
            unique case (state_q)
               ST_HUNT: begin
                  if (armed_q && is_sync) state_q <= ST_STATUS;
               end
               ST_SYNC: begin
                  if (is_sync) begin
                     state_q <= ST_STATUS;
                  end else begin
                     pulse_error_q <= 1'b1;
                     state_q       <= ST_HUNT;
                  end
               end
               ST_STATUS: begin
                  if (nib_ok) begin
                     stat_q    <= nib;
                     nib_idx_q <= '0;
                     crc_q     <= CRC_SEED;
                     state_q   <= ST_DATA;
                  end else begin
                     pulse_error_q <= 1'b1;
                     state_q       <= ST_HUNT;
                  end
               end
               ST_DATA: begin
                  if (nib_ok) begin
                     shift_q   <= {shift_q[W-5:0], nib};
                     crc_q     <= crc_step(crc_q, nib);
                     nib_idx_q <= nib_idx_q + IW'(1);
                     if (nib_idx_q == IW'(NIBBLES - 1)) state_q <= ST_CRC;
                  end else begin
                     pulse_error_q <= 1'b1;
                     state_q       <= ST_HUNT;
                  end
               end
               ST_CRC: begin
                  if (nib_ok) begin
                     if (crc_final(crc_q) == nib) begin
                        status_nibble_q <= stat_q;
                        data_fast_q     <= shift_q;
                        rx_crc_q        <= nib;
                        frame_valid_q   <= 1'b1;
                     end else begin
                        crc_error_q <= 1'b1;
                     end
                     state_q <= bus.optional_pause ? ST_PAUSE : ST_SYNC;
                  end else begin
                     pulse_error_q <= 1'b1;
                     state_q       <= ST_HUNT;
                  end
               end
               ST_PAUSE: begin
                  if (pause_ok) begin
                     state_q <= ST_SYNC;
                  end else begin
                     pulse_error_q <= 1'b1;
                     state_q       <= ST_HUNT;
                  end
               end
               default: state_q <= ST_HUNT;
            endcase
         end else if (sat && state_q != ST_HUNT) begin
            // Line stuck: silently drop back to hunting.
            state_q <= ST_HUNT;
         end
      end
   end

   assign bus.status_nibble = status_nibble_q;
   assign bus.data_fast     = data_fast_q;
   assign bus.rx_crc        = rx_crc_q;
   assign bus.frame_valid   = frame_valid_q;
   assign bus.crc_error     = crc_error_q;
   assign bus.pulse_error   = pulse_error_q;
   assign bus.busy          = (state_q != ST_HUNT);

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Self-checking bench for sent_rx_decoder: drives SENT pulse trains and
// compares decoded frames and strobes against a frame-level reference model.
module tb_sent_rx_decoder;

   localparam int CPT  = 4;
   localparam int LOWC = 4 * CPT;
   localparam logic [3:0] TAB [16] = '{
      4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
      4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5
   };

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sent_rx_decoder_if #(.NIBBLES(6)) bus ();

   sent_rx_decoder #(
      .CLK_PER_TICK (CPT),
      .NIBBLES      (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Event recorder: counts strobes, captures outputs on each good frame and
   // flags strobe overlap/width and output changes outside frame_valid.
   int          fv_cnt = 0, ce_cnt = 0, pe_cnt = 0, viol = 0;
   logic [31:0] got [256];
   logic [31:0] prev_out  = '0;
   logic [2:0]  prev_strb = '0;

   always @(negedge clk) begin
      logic [31:0] cur;
      logic [2:0]  s;
      cur = {bus.status_nibble, bus.data_fast, bus.rx_crc};
      s   = {bus.frame_valid, bus.crc_error, bus.pulse_error};
      if (reset) begin
         prev_out  = cur;
         prev_strb = '0;
      end else begin
         if (bus.frame_valid) begin
            got[fv_cnt[7:0]] = cur;
            fv_cnt++;
         end
         if (bus.crc_error)   ce_cnt++;
         if (bus.pulse_error) pe_cnt++;
         if ($countones(s) > 1) viol++;
         if ((s & prev_strb) != 3'b000) viol++;
         if (!bus.frame_valid && cur !== prev_out) viol++;
         prev_out  = cur;
         prev_strb = s;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [3:0] model_crc(input logic [23:0] d);
      logic [3:0] c;
      c = 4'h5;
      for (int i = 0; i < 6; i++) c = TAB[c] ^ d[23-4*i -: 4];
      return TAB[c];
   endfunction

   function automatic int jit(input bit en);
      return en ? int'($urandom_range(2)) - 1 : 0;
   endfunction

   task automatic send_pulse(input int clocks);
      bus.data_pulse = 1'b0;
      repeat (LOWC) @(negedge clk);
      bus.data_pulse = 1'b1;
      repeat (clocks - LOWC) @(negedge clk);
   endtask

   // upto < 6 stops after that many data nibbles and sends no CRC nibble.
   task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] c,
                             input bit j, input int sync_t, input int bad_pos, input int upto);
      send_pulse(sync_t * CPT + jit(j));
      send_pulse((12 + int'(st)) * CPT + jit(j));
      for (int i = 0; i < upto; i++) begin
         logic [3:0] v;
         v = d[23-4*i -: 4];
         send_pulse(((i == bad_pos) ? 30 : 12 + int'(v)) * CPT + jit(j));
      end
      if (upto == 6) send_pulse((12 + int'(c)) * CPT + jit(j));
   endtask

   task automatic tail();
      send_pulse(LOWC + 20);
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      reset              = 1'b1;
      bus.data_pulse     = 1'b1;
      bus.enable         = 1'b1;
      bus.optional_pause = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (bus.data_fast !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h want 000000", bus.data_fast); end
      n_vec++; if (bus.status_nibble !== 4'h0 || bus.rx_crc !== 4'h0) begin n_err++; $display("FAIL reset_nibbles: got %h/%h want 0/0", bus.status_nibble, bus.rx_crc); end
      n_vec++; if ({bus.frame_valid, bus.crc_error, bus.pulse_error} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b want 000", {bus.frame_valid, bus.crc_error, bus.pulse_error}); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      do_reset();
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_zero_frame();
      int f0, c0;
      do_reset();
      f0 = fv_cnt; c0 = ce_cnt;
      send_frame(4'h0, 24'h0, 4'h5, 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (fv_cnt - f0 !== 1) begin n_err++; $display("FAIL zero_valid_count: got %0d want 1", fv_cnt - f0); end
      n_vec++; if (ce_cnt - c0 !== 0) begin n_err++; $display("FAIL zero_crc_err: got %0d want 0", ce_cnt - c0); end
      n_vec++; if (got[f0[7:0]] !== {4'h0, 24'h0, 4'h5}) begin n_err++; $display("FAIL zero_frame: got %h want 00000005", got[f0[7:0]]); end
      n_vec++; if (bus.rx_crc !== 4'h5 || bus.data_fast !== 24'h0) begin n_err++; $display("FAIL zero_outputs: got %h/%h want 5/000000", bus.rx_crc, bus.data_fast); end
   endtask

   task automatic test_crc_fail();
      int f0, c0, p0;
      logic [3:0]  st;
      logic [23:0] d;
      do_reset();
      st = 4'($urandom_range(15)); d = 24'($urandom);
      f0 = fv_cnt; c0 = ce_cnt; p0 = pe_cnt;
      send_frame(st, d, model_crc(d), 1'b0, 56, -1, 6);
      send_frame(4'h0, 24'h0, 4'h4, 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (fv_cnt - f0 !== 1) begin n_err++; $display("FAIL crcfail_valid_count: got %0d want 1", fv_cnt - f0); end
      n_vec++; if (ce_cnt - c0 !== 1) begin n_err++; $display("FAIL crcfail_err_count: got %0d want 1", ce_cnt - c0); end
      n_vec++; if (pe_cnt - p0 !== 0) begin n_err++; $display("FAIL crcfail_pulse_err: got %0d want 0", pe_cnt - p0); end
      n_vec++; if ({bus.status_nibble, bus.data_fast, bus.rx_crc} !== {st, d, model_crc(d)}) begin n_err++;
         $display("FAIL crcfail_hold: got %h want %h", {bus.status_nibble, bus.data_fast, bus.rx_crc}, {st, d, model_crc(d)}); end
   endtask

   task automatic test_jitter();
      int f0;
      logic [3:0]  st [2];
      logic [23:0] d [2];
      do_reset();
      f0 = fv_cnt;
      for (int i = 0; i < 2; i++) begin
         st[i] = 4'($urandom_range(15)); d[i] = 24'($urandom);
         send_frame(st[i], d[i], model_crc(d[i]), 1'b1, 57, -1, 6);
      end
      tail();
      n_vec++; if (fv_cnt - f0 !== 2) begin n_err++; $display("FAIL jitter_valid_count: got %0d want 2", fv_cnt - f0); end
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (got[8'(f0 + i)] !== {st[i], d[i], model_crc(d[i])}) begin n_err++;
            $display("FAIL jitter_frame%0d: got %h want %h", i, got[8'(f0 + i)], {st[i], d[i], model_crc(d[i])}); end
      end
   endtask

   task automatic test_bad_nibble();
      int f0, p0;
      logic [3:0]  st;
      logic [23:0] d;
      do_reset();
      f0 = fv_cnt; p0 = pe_cnt;
      d = 24'($urandom);
      send_frame(4'h3, d, model_crc(d), 1'b0, 56, 3, 5);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bad_nib_busy: got %b want 0", bus.busy); end
      n_vec++; if (pe_cnt - p0 !== 1) begin n_err++; $display("FAIL bad_nib_pulse_err: got %0d want 1", pe_cnt - p0); end
      st = 4'($urandom_range(15)); d = 24'($urandom);
      send_frame(st, d, model_crc(d), 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (fv_cnt - f0 !== 1) begin n_err++; $display("FAIL bad_nib_resync_count: got %0d want 1", fv_cnt - f0); end
      n_vec++; if (got[f0[7:0]] !== {st, d, model_crc(d)}) begin n_err++;
         $display("FAIL bad_nib_resync_frame: got %h want %h", got[f0[7:0]], {st, d, model_crc(d)}); end
   endtask

   task automatic test_pause();
      int f0, p0;
      logic [3:0]  st [3];
      logic [23:0] d [3];
      do_reset();
      bus.optional_pause = 1'b1;
      f0 = fv_cnt; p0 = pe_cnt;
      for (int i = 0; i < 3; i++) begin
         st[i] = 4'($urandom_range(15)); d[i] = 24'($urandom);
      end
      send_frame(st[0], d[0], model_crc(d[0]), 1'b0, 56, -1, 6);
      send_pulse(100 * CPT);
      send_frame(st[1], d[1], model_crc(d[1]), 1'b0, 56, -1, 6);
      send_pulse(900 * CPT);
      send_frame(st[2], d[2], model_crc(d[2]), 1'b0, 56, -1, 6);
      tail();
      bus.optional_pause = 1'b0;
      n_vec++; if (fv_cnt - f0 !== 3) begin n_err++; $display("FAIL pause_valid_count: got %0d want 3", fv_cnt - f0); end
      n_vec++; if (pe_cnt - p0 !== 1) begin n_err++; $display("FAIL pause_long_err: got %0d want 1", pe_cnt - p0); end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (got[8'(f0 + i)] !== {st[i], d[i], model_crc(d[i])}) begin n_err++;
            $display("FAIL pause_frame%0d: got %h want %h", i, got[8'(f0 + i)], {st[i], d[i], model_crc(d[i])}); end
      end
   endtask

   task automatic test_reset_mid();
      int f0;
      logic [3:0]  st;
      logic [23:0] d;
      do_reset();
      d = 24'($urandom) | 24'h1;
      send_frame(4'hA, d, model_crc(d), 1'b0, 56, -1, 6);
      send_frame(4'h2, 24'h123456, 4'h0, 1'b0, 56, -1, 3);
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midreset_busy_before: got %b want 1", bus.busy); end
      #2 reset = 1'b1;
      #1;
      n_vec++; if ({bus.status_nibble, bus.data_fast, bus.rx_crc} !== 32'h0) begin n_err++;
         $display("FAIL midreset_outputs: got %h want 00000000", {bus.status_nibble, bus.data_fast, bus.rx_crc}); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      f0 = fv_cnt;
      st = 4'($urandom_range(15)); d = 24'($urandom);
      send_frame(st, d, model_crc(d), 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (fv_cnt - f0 !== 1) begin n_err++; $display("FAIL midreset_after_count: got %0d want 1", fv_cnt - f0); end
      n_vec++; if (got[f0[7:0]] !== {st, d, model_crc(d)}) begin n_err++;
         $display("FAIL midreset_after_frame: got %h want %h", got[f0[7:0]], {st, d, model_crc(d)}); end
   endtask

   task automatic test_enable();
      int f0, p0;
      logic [3:0]  st;
      logic [23:0] d;
      logic [31:0] a;
      do_reset();
      d = 24'($urandom);
      a = {4'h6, d, model_crc(d)};
      send_frame(4'h6, d, model_crc(d), 1'b0, 56, -1, 6);
      send_frame(4'h1, 24'hABCDEF, 4'h0, 1'b0, 56, -1, 2);
      bus.enable = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL enable_busy: got %b want 0", bus.busy); end
      n_vec++; if ({bus.status_nibble, bus.data_fast, bus.rx_crc} !== a) begin n_err++;
         $display("FAIL enable_hold: got %h want %h", {bus.status_nibble, bus.data_fast, bus.rx_crc}, a); end
      bus.enable = 1'b1;
      repeat (5) @(negedge clk);
      f0 = fv_cnt; p0 = pe_cnt;
      st = 4'($urandom_range(15)); d = 24'($urandom);
      send_frame(st, d, model_crc(d), 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (fv_cnt - f0 !== 1 || pe_cnt - p0 !== 0) begin n_err++;
         $display("FAIL enable_after: got valid %0d perr %0d want 1 0", fv_cnt - f0, pe_cnt - p0); end
      n_vec++; if ({bus.status_nibble, bus.data_fast, bus.rx_crc} !== {st, d, model_crc(d)}) begin n_err++;
         $display("FAIL enable_after_frame: got %h want %h", {bus.status_nibble, bus.data_fast, bus.rx_crc}, {st, d, model_crc(d)}); end
   endtask

   task automatic test_timeout();
      int p0, c0;
      logic [23:0] d;
      do_reset();
      d = 24'($urandom);
      send_frame(4'h9, d, model_crc(d), 1'b0, 56, -1, 6);
      tail();
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL timeout_busy_before: got %b want 1", bus.busy); end
      p0 = pe_cnt; c0 = ce_cnt;
      repeat (1023 * CPT + 40) @(negedge clk);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
      n_vec++; if (pe_cnt - p0 !== 0 || ce_cnt - c0 !== 0) begin n_err++;
         $display("FAIL timeout_no_error: got perr %0d cerr %0d want 0 0", pe_cnt - p0, ce_cnt - c0); end
   endtask

   task automatic test_back_to_back();
      int f0, c0, p0, n_bad;
      logic [31:0] exp_q [$];
      logic [3:0]  st, c;
      logic [23:0] d;
      do_reset();
      f0 = fv_cnt; c0 = ce_cnt; p0 = pe_cnt; n_bad = 0;
      for (int i = 0; i < 12; i++) begin
         st = 4'($urandom_range(15)); d = 24'($urandom);
         c = model_crc(d);
         if (i != 0 && $urandom_range(3) == 0) begin
            c = c ^ 4'($urandom_range(1, 15));
            n_bad++;
         end else begin
            exp_q.push_back({st, d, c});
         end
         send_frame(st, d, c, 1'b1, 55 + int'($urandom_range(2)), -1, 6);
      end
      tail();
      n_vec++; if (fv_cnt - f0 !== exp_q.size()) begin n_err++; $display("FAIL b2b_valid_count: got %0d want %0d", fv_cnt - f0, exp_q.size()); end
      n_vec++; if (ce_cnt - c0 !== n_bad) begin n_err++; $display("FAIL b2b_crc_err_count: got %0d want %0d", ce_cnt - c0, n_bad); end
      n_vec++; if (pe_cnt - p0 !== 0) begin n_err++; $display("FAIL b2b_pulse_err: got %0d want 0", pe_cnt - p0); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++; if (got[8'(f0 + i)] !== exp_q[i]) begin n_err++;
            $display("FAIL b2b_frame%0d: got %h want %h", i, got[8'(f0 + i)], exp_q[i]); end
      end
      n_vec++; if ({bus.status_nibble, bus.data_fast, bus.rx_crc} !== exp_q[exp_q.size() - 1]) begin n_err++;
         $display("FAIL b2b_last: got %h want %h", {bus.status_nibble, bus.data_fast, bus.rx_crc}, exp_q[exp_q.size() - 1]); end
   endtask

   task automatic test_strobe_rules();
      n_vec++; if (viol !== 0) begin n_err++; $display("FAIL strobe_rules: got %0d violations want 0", viol); end
   endtask

   initial begin
      bus.enable         = 1'b1;
      bus.optional_pause = 1'b0;
      bus.data_pulse     = 1'b1;
      test_reset();
      test_zero_frame();
      test_crc_fail();
      test_jitter();
      test_bad_nibble();
      test_pause();
      test_reset_mid();
      test_enable();
      test_timeout();
      test_back_to_back();
      test_strobe_rules();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
